// File: rtl/bram_weight_writer.sv
// bram_weight_writer: latches a flat vector of NUM_ELEMS elements on start,
// writes it into a single-port BRAM from BASE_ADDR upward, and optionally
// reads the region back and compares each word against the latched copy.
//
// Handshake: start is a request that is taken on any rising edge where the
// block is in IDLE or DONE; there is no ready signal, and start is ignored
// while busy. done is a level that stays high until the next accepted start.
module bram_weight_writer #(
  parameter int NUM_ELEMS    = 8,
  parameter int W            = 8,
  parameter int ADDR_WIDTH   = 18,
  parameter int BASE_ADDR    = 0,
  parameter int VERIFY       = 1,
  parameter int READ_LATENCY = 2,
  localparam int IDX_W       = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_ELEMS*W-1:0]  data_in,
  output logic                    bram_en,
  output logic                    bram_ren,
  output logic                    bram_wen,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [W-1:0]            bram_din,
  input  logic [W-1:0]            bram_dout,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [IDX_W-1:0]        err_index
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_ELEMS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [W-1:0]            shadow_q [NUM_ELEMS];
  logic                    bram_en_q;
  logic                    bram_ren_q;
  logic                    bram_wen_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic [W-1:0]            bram_din_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic [IDX_W-1:0]        err_index_q;

  // Read-index pipeline: one entry per issued read, aged READ_LATENCY edges.
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [IDX_W-1:0]        pipe_idx_q [READ_LATENCY];

  logic                    rd_issue_d;
  logic [IDX_W-1:0]        rd_idx_d;
  logic                    cmp_vld;
  logic [IDX_W-1:0]        cmp_idx;
  logic                    cmp_mismatch;

  // Decide whether a read is presented at this edge and which element it is.
  always_comb begin
    rd_issue_d = 1'b0;
    rd_idx_d   = '0;
    if (state_q == S_WRITE && idx_q == LAST_IDX && VERIFY != 0) begin
      rd_issue_d = 1'b1;
      rd_idx_d   = '0;
    end else if (state_q == S_VERIFY && bram_ren_q && idx_q != LAST_IDX) begin
      rd_issue_d = 1'b1;
      rd_idx_d   = idx_q + IDX_W'(1);
    end
  end

  // Compare the word arriving now against the latched element of the same index.
  always_comb begin
    cmp_vld      = pipe_vld_q[READ_LATENCY-1];
    cmp_idx      = pipe_idx_q[READ_LATENCY-1];
    cmp_mismatch = (bram_dout != shadow_q[cmp_idx]);
  end

  // Age issued read indices so they line up with the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_idx_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_issue_d;
      pipe_idx_q[0] <= rd_idx_d;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_idx_q[k] <= pipe_idx_q[k-1];
      end
    end
  end

  // Main FSM: sequences writes, then reads, and registers every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      for (int i = 0; i < NUM_ELEMS; i++) shadow_q[i] <= '0;
      bram_en_q   <= 1'b0;
      bram_ren_q  <= 1'b0;
      bram_wen_q  <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_ELEMS; i++) shadow_q[i] <= data_in[i*W +: W];
            state_q     <= S_WRITE;
            idx_q       <= '0;
            bram_en_q   <= 1'b1;
            bram_wen_q  <= 1'b1;
            bram_ren_q  <= 1'b0;
            bram_addr_q <= BASE;
            bram_din_q  <= data_in[W-1:0];
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
          end
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            if (VERIFY != 0) begin
              state_q     <= S_VERIFY;
              idx_q       <= '0;
              bram_wen_q  <= 1'b0;
              bram_ren_q  <= 1'b1;
              bram_addr_q <= BASE;
            end else begin
              state_q    <= S_DONE;
              bram_en_q  <= 1'b0;
              bram_wen_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end else begin
            idx_q       <= idx_q + IDX_W'(1);
            bram_addr_q <= bram_addr_q + ADDR_WIDTH'(1);
            bram_din_q  <= shadow_q[idx_q + IDX_W'(1)];
          end
        end
        S_VERIFY: begin
          // Issue side: one read per edge until the last address, then drain.
          if (bram_ren_q) begin
            if (idx_q == LAST_IDX) begin
              bram_ren_q <= 1'b0;
            end else begin
              idx_q       <= idx_q + IDX_W'(1);
              bram_addr_q <= bram_addr_q + ADDR_WIDTH'(1);
            end
          end
          // Compare side: keep only the first mismatching index.
          if (cmp_vld) begin
            if (cmp_mismatch && !error_q) begin
              error_q     <= 1'b1;
              err_index_q <= cmp_idx;
            end
            if (cmp_idx == LAST_IDX) begin
              state_q    <= S_DONE;
              bram_en_q  <= 1'b0;
              bram_ren_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_ren  = bram_ren_q;
  assign bram_wen  = bram_wen_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_bram_weight_writer.sv
// Bench for bram_weight_writer: one instance with readback verification at a
// high base address, one write-only instance, each with a small BRAM model.
module tb_bram_weight_writer;

  localparam int BASE_V = 92160;
  localparam int BASE_W = 0;

  logic clk = 1'b0;
  logic rst_n;

  // verify instance signals
  logic        v_start;
  logic [63:0] v_data;
  logic        v_en, v_ren, v_wen;
  logic [17:0] v_addr;
  logic [7:0]  v_din;
  logic [7:0]  v_dout = 8'h00;
  logic        v_busy, v_done, v_error;
  logic [2:0]  v_err_index;

  // write-only instance signals
  logic        w_start;
  logic [63:0] w_data;
  logic        w_en, w_ren, w_wen;
  logic [17:0] w_addr;
  logic [7:0]  w_din;
  logic [7:0]  w_dout = 8'h00;
  logic        w_busy, w_done, w_error;
  logic [2:0]  w_err_index;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_v [16];
  logic [7:0]  mem_w [16];
  logic        corrupt_a = 1'b0;
  logic        corrupt_b = 1'b0;
  logic        w_ren_seen = 1'b0;
  int          v_wr_cnt = 0;
  int          w_wr_cnt = 0;
  logic [31:0] exp_v_q[$];
  logic [31:0] exp_w_q[$];

  bram_weight_writer #(
    .NUM_ELEMS(8), .W(8), .ADDR_WIDTH(18), .BASE_ADDR(BASE_V),
    .VERIFY(1), .READ_LATENCY(2)
  ) u_dut_v (
    .clk(clk), .rst_n(rst_n), .start(v_start), .data_in(v_data),
    .bram_en(v_en), .bram_ren(v_ren), .bram_wen(v_wen), .bram_addr(v_addr),
    .bram_din(v_din), .bram_dout(v_dout), .busy(v_busy), .done(v_done),
    .error(v_error), .err_index(v_err_index)
  );

  bram_weight_writer #(
    .NUM_ELEMS(8), .W(8), .ADDR_WIDTH(18), .BASE_ADDR(BASE_W),
    .VERIFY(0), .READ_LATENCY(2)
  ) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .data_in(w_data),
    .bram_en(w_en), .bram_ren(w_ren), .bram_wen(w_wen), .bram_addr(w_addr),
    .bram_din(w_din), .bram_dout(w_dout), .busy(w_busy), .done(w_done),
    .error(w_error), .err_index(w_err_index)
  );

  // clock / reset
  always #5 clk = ~clk;

  // BRAM models: write commit and one-edge registered read
  always @(posedge clk) begin
    if (v_en === 1'b1 && v_wen === 1'b1) mem_v[4'(v_addr - 18'(BASE_V))] <= v_din;
    if (v_en === 1'b1 && v_ren === 1'b1) begin
      if ((corrupt_a && v_addr == 18'd92165) || (corrupt_b && v_addr == 18'd92167))
        v_dout <= 8'hFF;
      else
        v_dout <= mem_v[4'(v_addr - 18'(BASE_V))];
    end
    if (w_en === 1'b1 && w_wen === 1'b1) mem_w[4'(w_addr - 18'(BASE_W))] <= w_din;
    if (w_en === 1'b1 && w_ren === 1'b1) w_dout <= mem_w[4'(w_addr - 18'(BASE_W))];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every committed write is matched against the expected queue
  always @(negedge clk) begin
    if (v_en === 1'b1 && v_wen === 1'b1) begin
      v_wr_cnt++;
      if (exp_v_q.size() == 0) check("v_wr_extra", {14'd0, v_addr}, 32'hFFFF_FFFF);
      else check("v_wr", {6'd0, v_addr, v_din}, exp_v_q.pop_front());
    end
    if (w_en === 1'b1 && w_wen === 1'b1) begin
      w_wr_cnt++;
      if (exp_w_q.size() == 0) check("w_wr_extra", {14'd0, w_addr}, 32'hFFFF_FFFF);
      else check("w_wr", {6'd0, w_addr, w_din}, exp_w_q.pop_front());
    end
    if (w_ren === 1'b1) w_ren_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_v(input string tag);
    check({tag, "_ctl"}, {26'd0, v_en, v_ren, v_wen, v_busy, v_done, v_error}, 32'd0);
    check({tag, "_addr"}, {14'd0, v_addr}, 32'd0);
    check({tag, "_din_ei"}, {21'd0, v_din, v_err_index}, 32'd0);
  endtask

  // driver: present data with start and pass the accepting edge e0
  task automatic start_v(input logic [63:0] d);
    exp_v_q.delete();
    v_wr_cnt = 0;
    for (int i = 0; i < 8; i++) exp_v_q.push_back({6'd0, 18'(BASE_V + i), d[i*8 +: 8]});
    v_data  = d;
    v_start = 1'b1;
    tick(1);
    v_start = 1'b0;
    check("v_accept", {28'd0, v_busy, v_en, v_wen, v_done}, 32'b1110);
    check("v_first_addr_din", {6'd0, v_addr, v_din}, {6'd0, 18'(BASE_V), d[7:0]});
  endtask

  task automatic start_w(input logic [63:0] d);
    exp_w_q.delete();
    w_wr_cnt = 0;
    for (int i = 0; i < 8; i++) exp_w_q.push_back({6'd0, 18'(BASE_W + i), d[i*8 +: 8]});
    w_data  = d;
    w_start = 1'b1;
    tick(1);
    w_start = 1'b0;
    check("w_accept", {28'd0, w_busy, w_en, w_wen, w_done}, 32'b1110);
  endtask

  // bounded wait for done; 'from' is the edge count already elapsed since e0
  task automatic wait_done_v(input int from, output int at);
    at = from;
    while (v_done !== 1'b1 && at < 60) begin
      tick(1);
      at++;
    end
  endtask

  task automatic check_v_end(input string tag);
    check({tag, "_wr_cnt"}, 32'(v_wr_cnt), 32'd8);
    check({tag, "_q_empty"}, 32'(exp_v_q.size()), 32'd0);
    check({tag, "_idle_ctl"}, {28'd0, v_en, v_ren, v_wen, v_busy}, 32'd0);
  endtask

  logic [63:0] d1 = 64'h0807_0605_0403_0201;
  int at;

  initial begin
    rst_n   = 1'b1;
    v_start = 1'b1;
    v_data  = d1;
    w_start = 1'b1;
    w_data  = 64'h0;

    // 1. asynchronous reset mid-clock, start held high
    #3 rst_n = 1'b0;
    #1;
    check_zero_v("rst_async");
    check("rst_w_ctl", {26'd0, w_en, w_ren, w_wen, w_busy, w_done, w_error}, 32'd0);
    tick(3);
    check("rst_hold_start", {30'd0, v_busy, v_en}, 32'd0);
    v_start = 1'b0;
    w_start = 1'b0;
    rst_n   = 1'b1;
    tick(2);
    check_zero_v("post_rst_idle");

    // 2. verified write, clean readback
    start_v(d1);
    tick(8);
    check("v_e8_verify", {28'd0, v_en, v_ren, v_wen, v_busy}, 32'b1101);
    check("v_e8_addr", {14'd0, v_addr}, 32'(BASE_V));
    tick(8);
    check("v_e16_ren_drop", {29'd0, v_ren, v_busy, v_done}, 32'b010);
    tick(1);
    check("v_e17_done", {30'd0, v_done, v_error}, 32'b10);
    check_v_end("v_clean");
    for (int i = 0; i < 8; i++) check($sformatf("v_mem%0d", i), {24'd0, mem_v[i]}, 32'(i + 1));

    // 3a. single corrupted readback (restart from DONE also clears error)
    corrupt_a = 1'b1;
    start_v(d1);
    wait_done_v(0, at);
    check("mis1_done_edge", 32'(at), 32'd17);
    check("mis1_err", {28'd0, v_error, v_err_index}, {28'd0, 1'b1, 3'd5});
    check_v_end("mis1");

    // 3b. second corrupted address keeps the first index
    corrupt_b = 1'b1;
    start_v(d1);
    check("mis2_err_clear", {28'd0, v_error, v_err_index}, 32'd0);
    wait_done_v(0, at);
    check("mis2_done_edge", 32'(at), 32'd17);
    check("mis2_err", {28'd0, v_error, v_err_index}, {28'd0, 1'b1, 3'd5});
    corrupt_a = 1'b0;
    corrupt_b = 1'b0;

    // 4. start and data_in changes while busy are ignored
    start_v(d1);
    tick(2);
    v_start = 1'b1;
    v_data  = {8{8'hAA}};
    tick(1);
    v_start = 1'b0;
    wait_done_v(3, at);
    check("busy_ign_done_edge", 32'(at), 32'd17);
    check("busy_ign_err", {31'd0, v_error}, 32'd0);
    check_v_end("busy_ign");

    // 5. reset mid-transfer, then a fresh transfer
    start_v(d1);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check_zero_v("rst_mid");
    tick(3);
    check("rst_mid_no_done", {31'd0, v_done}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    start_v(64'h1122_3344_5566_7788);
    wait_done_v(0, at);
    check("rst_fresh_done_edge", 32'(at), 32'd17);
    check("rst_fresh_err", {31'd0, v_error}, 32'd0);
    check_v_end("rst_fresh");

    // 6. write-only instance, then restart from DONE with new data
    start_w(64'h0102_0304_0506_0708);
    tick(7);
    check("w_e7", {30'd0, w_busy, w_done}, 32'b10);
    tick(1);
    check("w_e8_done", {28'd0, w_done, w_busy, w_en, w_wen}, 32'b1000);
    check("w_wr_cnt1", 32'(w_wr_cnt), 32'd8);
    start_w(64'hF0E0_D0C0_B0A0_9080);
    tick(7);
    check("w2_e7", {30'd0, w_busy, w_done}, 32'b10);
    tick(1);
    check("w2_e8_done", {30'd0, w_done, w_busy}, 32'b10);
    check("w2_wr_cnt", 32'(w_wr_cnt), 32'd8);
    check("w2_q_empty", 32'(exp_w_q.size()), 32'd0);
    check("w_mem0", {24'd0, mem_w[0]}, 32'h80);
    check("w_mem7", {24'd0, mem_w[7]}, 32'hF0);
    check("w_ren_never", {31'd0, w_ren_seen}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
